// File: rtl/pipeline_ctrl.sv
// Hazard unit for a 5-stage pipeline: operand forwarding, load-use stall, branch flush,
// and a data-miss wait FSM with a sticky watchdog and a saturating stall counter.
module pipeline_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  Rs1E,
  input  logic [4:0]  Rs2E,
  input  logic [4:0]  RdE,
  input  logic [1:0]  ResultSrcE,
  input  logic        PCSrcE,
  input  logic [4:0]  RdM,
  input  logic [4:0]  RdW,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic        MissM,
  input  logic        RefillDone,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        StallM,
  output logic        FlushD,
  output logic        FlushE,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        MemTimeout,
  output logic [15:0] StallCount
);

  typedef enum logic [1:0] {
    S_RUN         = 2'd0,
    S_MEM_WAIT    = 2'd1,
    S_MEM_RELEASE = 2'd2
  } state_t;

  state_t      r_state;
  logic [7:0]  r_wait_cnt;
  logic        r_timeout;
  logic [15:0] r_stall_cnt;

  logic        w_load_use;
  logic        w_stall_f;
  logic        w_stall_d;
  logic        w_stall_e;
  logic        w_stall_m;
  logic        w_flush_d;
  logic        w_flush_e;

  // M-stage result is newer than W-stage, so it takes priority.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic [4:0] rd_m,
    input logic       we_m,
    input logic [4:0] rd_w,
    input logic       we_w
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (we_m && (rd_m != 5'd0) && (rd_m == rs))
      sel = 2'b10;
    else if (we_w && (rd_w != 5'd0) && (rd_w == rs))
      sel = 2'b01;
    return sel;
  endfunction

  assign ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
  assign ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);

  assign w_load_use = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                      ((RdE == Rs1D) || (RdE == Rs2D));

  // Hazard outputs react in the same cycle as the hazard, so they are decoded from
  // the registered state plus live inputs; a taken branch overrides a load-use stall.
  always_comb begin
    w_stall_f = 1'b0;
    w_stall_d = 1'b0;
    w_stall_e = 1'b0;
    w_stall_m = 1'b0;
    w_flush_d = 1'b0;
    w_flush_e = 1'b0;
    if (rst_n) begin
      if (r_state == S_MEM_WAIT) begin
        w_stall_f = 1'b1;
        w_stall_d = 1'b1;
        w_stall_e = 1'b1;
        w_stall_m = 1'b1;
      end else if (PCSrcE) begin
        w_flush_d = 1'b1;
        w_flush_e = 1'b1;
      end else if (w_load_use) begin
        w_stall_f = 1'b1;
        w_stall_d = 1'b1;
        w_flush_e = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_RUN;
      r_wait_cnt <= 8'd0;
      r_timeout  <= 1'b0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (MissM) begin
            r_state    <= S_MEM_WAIT;
            r_wait_cnt <= 8'd0;
          end
        end
        S_MEM_WAIT: begin
          if (r_wait_cnt != 8'hFF)
            r_wait_cnt <= r_wait_cnt + 8'd1;
          // Flag goes up on the same edge the counter lands on 255.
          if (r_wait_cnt == 8'hFE)
            r_timeout <= 1'b1;
          if (RefillDone)
            r_state <= S_MEM_RELEASE;
        end
        S_MEM_RELEASE: r_state <= S_RUN;
        default:       r_state <= S_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_stall_cnt <= 16'd0;
    else if (w_stall_f && (r_stall_cnt != 16'hFFFF))
      r_stall_cnt <= r_stall_cnt + 16'd1;
  end

  assign StallF     = w_stall_f;
  assign StallD     = w_stall_d;
  assign StallE     = w_stall_e;
  assign StallM     = w_stall_m;
  assign FlushD     = w_flush_d;
  assign FlushE     = w_flush_e;
  assign MemTimeout = r_timeout;
  assign StallCount = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: forwarding, load-use, branch flush, miss wait and watchdog.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0]  ResultSrcE;
  logic        PCSrcE, RegWriteM, RegWriteW, MissM, RefillDone;
  logic        StallF, StallD, StallE, StallM, FlushD, FlushE, MemTimeout;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [15:0] StallCount;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pipeline_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
    .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MissM(MissM), .RefillDone(RefillDone),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .MemTimeout(MemTimeout), .StallCount(StallCount)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    ResultSrcE = 2'b00; PCSrcE = 0; RegWriteM = 0; RegWriteW = 0;
    MissM = 0; RefillDone = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    // Reset state, with forwarding still live
    RdM = 5; RegWriteM = 1; Rs1E = 5;
    ResultSrcE = 2'b01; RdE = 7; Rs2D = 7; PCSrcE = 1;
    #3;
    chk("rst_stallF", StallF, 0);
    chk("rst_flushD", FlushD, 0);
    chk("rst_flushE", FlushE, 0);
    chk("rst_cnt", StallCount, 0);
    chk("rst_timeout", MemTimeout, 0);
    chk("rst_fwdA", ForwardAE, 2'b10);
    clear_inputs();
    #9 rst_n = 1'b1;
    tick();

    // Forwarding
    RdM = 5; RegWriteM = 1; Rs1E = 5; RdW = 5; RegWriteW = 1;
    #1 chk("fwdA_M_prio", ForwardAE, 2'b10);
    RegWriteM = 0;
    #1 chk("fwdA_W", ForwardAE, 2'b01);
    RdM = 0; RegWriteM = 1; Rs2E = 0; RdW = 0; RegWriteW = 1; Rs1E = 3;
    #1 chk("fwdB_x0", ForwardBE, 2'b00);
    RdW = 3;
    #1 chk("fwdB_W", ForwardBE, 2'b00);
    chk("fwdA_W3", ForwardAE, 2'b01);
    Rs2E = 9; RdM = 9;
    #1 chk("fwdB_M", ForwardBE, 2'b10);
    clear_inputs();
    tick();

    // Load-use stall
    ResultSrcE = 2'b01; RdE = 7; Rs2D = 7;
    #1;
    chk("lu_stallF", StallF, 1);
    chk("lu_stallD", StallD, 1);
    chk("lu_flushE", FlushE, 1);
    chk("lu_flushD", FlushD, 0);
    chk("lu_stallE", StallE, 0);
    chk("lu_stallM", StallM, 0);
    chk("lu_cnt0", StallCount, 0);
    tick();
    clear_inputs();
    #1;
    chk("lu_cnt1", StallCount, 1);
    chk("lu_over", StallF, 0);

    // Load-use together with branch: flush wins
    ResultSrcE = 2'b01; RdE = 7; Rs2D = 7; PCSrcE = 1;
    #1;
    chk("br_flushD", FlushD, 1);
    chk("br_flushE", FlushE, 1);
    chk("br_stallF", StallF, 0);
    chk("br_stallD", StallD, 0);
    tick();
    clear_inputs();
    #1 chk("br_cnt", StallCount, 1);

    // Load to x0 is never a hazard
    ResultSrcE = 2'b01; RdE = 0; Rs1D = 0;
    #1 chk("lu_x0", StallF, 0);
    clear_inputs();

    // RefillDone in RUN is ignored
    RefillDone = 1;
    tick();
    RefillDone = 0;
    #1 chk("refill_run", StallF, 0);

    // Asynchronous reset clears the counter mid-cycle
    rst_n = 1'b0;
    #1 chk("arst_cnt", StallCount, 0);
    rst_n = 1'b1;
    tick();

    // Miss, refill on the 11th wait cycle, then one release cycle
    MissM = 1;
    #1 chk("miss_cyc0", StallF, 0);
    tick();
    MissM = 0;
    for (int i = 1; i <= 11; i++) begin
      RefillDone = (i == 11);
      MissM = (i == 3);
      PCSrcE = (i == 5);
      #1;
      chk($sformatf("wait%0d_stallF", i), StallF, 1);
      chk($sformatf("wait%0d_stallM", i), StallM, 1);
      chk($sformatf("wait%0d_flushD", i), FlushD, 0);
      tick();
    end
    clear_inputs();
    MissM = 1;
    ResultSrcE = 2'b01; RdE = 7; Rs1D = 7;
    #1;
    chk("rel_stallM", StallM, 0);
    chk("rel_stallE", StallE, 0);
    chk("rel_lu_stallF", StallF, 1);
    chk("rel_lu_flushE", FlushE, 1);
    chk("rel_cnt", StallCount, 11);
    tick();
    clear_inputs();
    #1;
    chk("run_after_rel", StallM, 0);
    chk("run_cnt", StallCount, 12);

    // Miss with branch: branch outputs this cycle, wait from the next
    MissM = 1; PCSrcE = 1;
    #1;
    chk("mb_flushD", FlushD, 1);
    chk("mb_stallF", StallF, 0);
    tick();
    clear_inputs();
    for (int k = 1; k <= 300; k++) begin
      #1;
      if (k == 1) chk("wd_stallF1", StallF, 1);
      if (k == 255) chk("wd_to255", MemTimeout, 0);
      if (k == 256) chk("wd_to256", MemTimeout, 1);
      if (k == 300) begin
        chk("wd_to300", MemTimeout, 1);
        chk("wd_stay_wait", StallM, 1);
      end
      if (k < 300) tick();
    end
    rst_n = 1'b0;
    #1;
    chk("wd_rst_to", MemTimeout, 0);
    chk("wd_rst_stallM", StallM, 0);
    chk("wd_rst_cnt", StallCount, 0);
    rst_n = 1'b1;
    tick();
    MissM = 1;
    #1 chk("post_rst_run", StallF, 0);
    tick();
    MissM = 0;
    #1 chk("post_rst_miss", StallF, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have ports (name  direction  width  meaning), clock and reset first, as listed in REQ-002 to REQ-007.
REQ-002 clk  in  1  single clock; all state updates on its rising edge; rst_n  in  1  asynchronous, active-low reset.
REQ-003 Rs1D, Rs2D  in  5 each  decode-stage source registers; Rs1E, Rs2E, RdE  in  5 each  execute-stage source and destination registers.
REQ-004 ResultSrcE  in  2  execute-stage result select, where 01 = load; PCSrcE  in  1  branch or jump taken in execute.
REQ-005 RdM, RdW  in  5 each  destination registers; RegWriteM, RegWriteW  in  1 each  write enables for memory and writeback stages.
REQ-006 MissM  in  1  data-memory miss request; RefillDone  in  1  one-cycle pulse, refill complete.
REQ-007 Outputs:
- StallF, StallD, StallE, StallM  out  1 each  hold stage registers;
- FlushD, FlushE  out  1 each  clear stage registers;
- ForwardAE, ForwardBE  out  2 each  operand select;
- MemTimeout  out  1  sticky watchdog flag;
- StallCount  out  16  performance counter.

Function
REQ-008 Forwarding SHALL be combinational; ForwardAE = 10 if RegWriteM, RdM != 0 and RdM == Rs1E.
REQ-009 Otherwise ForwardAE = 01 if RegWriteW, RdW != 0 and RdW == Rs1E; otherwise 00. The M-stage match SHALL have priority over W.
REQ-010 ForwardBE SHALL follow REQ-008 and REQ-009 using Rs2E.
REQ-011 The FSM SHALL have three states: RUN, MEM_WAIT, MEM_RELEASE.
REQ-012 RUN -> MEM_WAIT when MissM = 1.
REQ-013 MEM_WAIT -> MEM_RELEASE when RefillDone = 1; MEM_RELEASE -> RUN unconditionally after 1 cycle.
REQ-014 In MEM_WAIT, StallF/D/E/M SHALL all be 1 and FlushD/FlushE SHALL be 0, regardless of the other inputs.
REQ-015 In MEM_RELEASE, StallM SHALL be 0 and the RUN rules (REQ-016 to REQ-019) SHALL apply to the remaining outputs.
REQ-016 In RUN, load-use SHALL be detected when ResultSrcE = 01, RdE != 0, and RdE == Rs1D or RdE == Rs2D.
REQ-017 On load-use in RUN: StallF = StallD = 1 and FlushE = 1 for exactly that cycle; StallE = StallM = 0.
REQ-018 In RUN with PCSrcE = 1: FlushD = FlushE = 1, StallF = StallD = 0.
REQ-019 When PCSrcE and load-use occur together, the flush SHALL win and no stall SHALL be raised.
REQ-020 MissM asserted together with PCSrcE or load-use in RUN SHALL give MEM_WAIT outputs only from the next cycle; that cycle's outputs SHALL follow REQ-017 to REQ-019.
REQ-021 A wait counter (8-bit) SHALL clear on entry to MEM_WAIT and increment each cycle in MEM_WAIT.
REQ-022 When the wait counter reaches 255, MemTimeout SHALL set and stay 1 until reset; the FSM SHALL remain in MEM_WAIT.
REQ-023 StallCount SHALL increment by 1 on every cycle with StallF = 1, and SHALL saturate at 0xFFFF (no wrap).
REQ-024 RefillDone outside MEM_WAIT SHALL be ignored.
REQ-025 MissM in MEM_WAIT or MEM_RELEASE SHALL be ignored.

Reset
REQ-026 rst_n = 0 SHALL immediately force: state RUN, wait counter 0, StallCount 0, MemTimeout 0.
REQ-027 While rst_n = 0, the stall and flush outputs SHALL be 0; forwarding outputs SHALL remain purely combinational.
REQ-028 Reset asserted in MEM_WAIT SHALL abort the wait with no MEM_RELEASE cycle.

Verification
REQ-029 RdM=5, RegWriteM=1, Rs1E=5, RdW=5, RegWriteW=1 -> ForwardAE=10.
REQ-030 RdM=0, RegWriteM=1, Rs2E=0 -> ForwardBE=00.
REQ-031 ResultSrcE=01, RdE=7, Rs2D=7, PCSrcE=0 -> StallF=StallD=FlushE=1 for one cycle; StallCount 0 -> 1.
REQ-032 The same as REQ-031 with PCSrcE=1 -> FlushD=FlushE=1, StallF=0; StallCount unchanged.
REQ-033 MissM pulse, RefillDone after 10 cycles -> 4 stalls high for 11 cycles, then one MEM_RELEASE cycle with StallM=0, then RUN; StallCount = 11.
REQ-034 MissM with no RefillDone for 300 cycles -> MemTimeout=1 from cycle 256; rst_n low -> MemTimeout=0 and state RUN immediately.
